// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_kind_t;
endpackage

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - column drive, row sync and per-scan classification.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_scan_done,
  output scan_kind_t o_scan_kind,
  output logic [3:0] o_scan_code
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [1:0]          r_col;
  logic [3:0]          r_row_s1;
  logic [3:0]          r_row_s2;
  logic [NUM_KEYS-1:0] r_acc;

  logic                w_slot_end;
  logic                w_scan_done;
  logic [NUM_KEYS-1:0] w_sample;
  logic [4:0]          w_cnt;
  logic [3:0]          w_code;

  assign w_slot_end  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_scan_done = w_slot_end && (r_col == 2'd3);

  // The column-3 sample is merged in combinationally so the completed scan is judged on the same edge.
  always_comb begin
    w_sample = r_acc;
    if (w_slot_end) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        w_sample[{2'(r), r_col}] = ~r_row_s2[r];
      end
    end
  end

  always_comb begin
    w_cnt  = '0;
    w_code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_sample[i]) begin
        w_cnt  = w_cnt + 5'd1;
        w_code = 4'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_s1  <= '1;
      r_row_s2  <= '1;
      r_div_cnt <= '0;
      r_col     <= '0;
      r_acc     <= '0;
    end else begin
      r_row_s1 <= i_row;
      r_row_s2 <= r_row_s1;
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_col     <= r_col + 2'd1;
        r_acc     <= w_scan_done ? '0 : w_sample;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign o_col       = ~(4'b0001 << r_col);
  assign o_scan_done = w_scan_done;
  assign o_scan_code = w_code;
  assign o_scan_kind = (w_cnt == 5'd0) ? NONE : ((w_cnt == 5'd1) ? SINGLE : MULTI);
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner top: scan-level debounce FSM and key outputs.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic             w_scan_done;
  scan_kind_t       w_scan_kind;
  logic [3:0]       w_scan_code;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_count_full;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_row       (row_in),
    .o_col       (col_out),
    .o_scan_done (w_scan_done),
    .o_scan_kind (w_scan_kind),
    .o_scan_code (w_scan_code)
  );

  assign w_count_inc  = (r_count == CNT_W'(DEBOUNCE_SCANS)) ? r_count : r_count + CNT_W'(1);
  assign w_count_full = (w_count_inc == CNT_W'(DEBOUNCE_SCANS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        case (r_state)
          IDLE: begin
            if (w_scan_kind == SINGLE) begin
              r_state <= CAND;
              r_cand  <= w_scan_code;
              r_count <= CNT_W'(1);
            end
          end
          CAND: begin
            if (w_scan_kind == SINGLE && w_scan_code == r_cand) begin
              r_count <= w_count_inc;
              if (w_count_full) begin
                r_state     <= PRESSED;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else if (w_scan_kind == SINGLE) begin
              r_cand  <= w_scan_code;
              r_count <= CNT_W'(1);
            end else begin
              r_state <= IDLE;
              r_count <= '0;
            end
          end
          PRESSED: begin
            // No rollover: any key activity keeps us here until a full release.
            if (w_scan_kind == NONE) begin
              r_state <= RELEASE;
              r_count <= CNT_W'(1);
            end
          end
          RELEASE: begin
            if (w_scan_kind == NONE) begin
              r_count <= w_count_inc;
              if (w_count_full) begin
                r_state    <= IDLE;
                r_count    <= '0;
                r_key_held <= 1'b0;
              end
            end else begin
              r_state <= PRESSED;
              r_count <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart of the seven-segment output path.
- Drives the keypad columns one at a time and samples the rows.
- Debounces over whole scans, rejects multi-key presses, and emits a 4-bit key code with a one-cycle valid strobe.
- The code feeds the accumulator/display datapath in place of push-button inputs.

Parameters:
- SCAN_DIV, 1000, clk cycles per column slot; minimum 4, which covers the 2-flop sync plus settling.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows; active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  column drive; active-low, exactly one bit low at any time.
- key_code  output  4  last accepted key, code = row*4 + col.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  high while an accepted key has not yet been debounced as released.

Behaviour:
- Reset (async, reset=0):
  - div_cnt=0, col=0, so col_out=4'b1110.
  - key_code=0, key_valid=0, key_held=0, FSM=IDLE, debounce count=0, scan accumulator cleared.
- Synchronisation: row_in passes through a 2-flop synchroniser before any use.
- Column slot timing:
  - div_cnt counts 0..SCAN_DIV-1, then wraps and col advances 0->1->2->3->0.
  - col_out = ~(1<<col).
- Sampling: at div_cnt==SCAN_DIV-1, the synced rows for the current col are captured into the scan accumulator.
- scan_done fires at div_cnt==SCAN_DIV-1 with col==3, i.e. once every 4*SCAN_DIV cycles.
- Scan result is evaluated on the completed scan, including the col-3 sample:
  - NONE: zero intersections low.
  - SINGLE(c): exactly one intersection low; c = row*4 + col.
  - MULTI: two or more low.
  - The accumulator clears for the next scan.
- FSM updates only on scan_done (count = consecutive qualifying scans):
  - IDLE:
    - SINGLE(c) -> CAND, cand=c, count=1.
    - NONE or MULTI -> stay.
  - CAND:
    - SINGLE(cand) -> count+1; on reaching DEBOUNCE_SCANS -> PRESSED, key_code<=cand, key_valid=1 for the next clk cycle only.
    - SINGLE(other) -> restart with cand=other, count=1.
    - NONE or MULTI -> IDLE, count=0.
  - PRESSED (key_held=1):
    - NONE -> RELEASE, count=1.
    - SINGLE(any) or MULTI -> stay. There is no rollover: a second key produces no event until full release.
  - RELEASE (key_held=1):
    - NONE -> count+1; on reaching DEBOUNCE_SCANS -> IDLE, key_held=0.
    - Anything else -> PRESSED, count=0. A bounce produces no new key_valid.
- key_held is high exactly in PRESSED and RELEASE; it rises in the same cycle key_valid rises.
- key_code holds its value until the next accepted press.
- Latency: key_valid is asserted 1 cycle after the DEBOUNCE_SCANS-th consecutive SINGLE(c) scan_done.
- Counter widths: derived via $clog2; the count saturates at DEBOUNCE_SCANS and never wraps.
- Reset asserted mid-scan or mid-debounce: all state drops immediately to reset values; no key_valid is produced during or on exit from reset.

Decomposition:
- keypad_pkg:
  - state enum {IDLE, CAND, PRESSED, RELEASE}.
  - NUM_ROWS=4, NUM_COLS=4.
  - scan-result enum {NONE, SINGLE, MULTI}.
- Sub-module keypad_col_scan owns:
  - the row synchroniser, div_cnt, col counter and col_out;
  - the per-scan accumulator;
  - outputs scan_done, scan_kind and scan_code.
- Top keypad_scanner holds the debounce FSM and the output registers.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles). The bench models the matrix combinationally: row r is driven low when col_out[c]==0 and key (r,c) is pressed.
1. Reset release with no keys -> col_out walks 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; key_code=0, key_held=0.
2. Press (1,2) from a scan boundary and hold 10 scans -> exactly one key_valid pulse, key_code=6, one cycle after the 3rd scan_done. key_held=1 until 3 NONE scans after release.
3. Press (3,3) with bounce (alternating present/absent per scan for 4 scans), then stable -> no key_valid during the bounce; one pulse with key_code=15 after 3 stable scans.
4. Press (0,0) and (2,1) simultaneously -> MULTI every scan, no key_valid. Release (2,1) -> key_valid with key_code=0 after 3 scans.
5. Hold (0,1) until accepted (code 1), add (1,0), then release (0,1) -> no new key_valid and key_code stays 1; key_held stays 1 until all keys are released for 3 scans.
6. Assert reset in CAND after 2 matching scans -> outputs return to reset values immediately; after deassert the debounce restarts from count 0 and needs 3 fresh scans.
